// File: rtl/reset_seq_pkg.sv
// Shared state encoding and width helpers for the reset sequencer.
// ST_FAULT exists only when RESET_SEQ_TIMEOUT_EN is defined.
package reset_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_HOLD      = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_RUN       = 3'd4
`ifdef RESET_SEQ_TIMEOUT_EN
      ,ST_FAULT    = 3'd5
`endif
   } state_e;

   // Width of a saturating counter that must be able to hold max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of a stage index; a single stage still gets one bit.
   function automatic int idx_width(input int num);
      return (num > 1) ? $clog2(num) : 1;
   endfunction

endpackage

// File: rtl/reset_seq_lock_filter.sv
// Qualifies PLL lock after LOCK_FILTER consecutive high samples; qualified_o
// flags the edge that carries the final high sample.
module reset_seq_lock_filter
   import reset_seq_pkg::*;
#(
   parameter int LOCK_FILTER = 8
) (
   input  logic clk_i,
   input  logic srst_i,
   input  logic clear_i,
   input  logic lock_i,
   output logic qualified_o
);

   localparam int CNT_W = cnt_width(LOCK_FILTER);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LOCK_FILTER);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Consecutive-high counter; any low sample or clear restarts it.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || !lock_i) begin
         cnt_d = CNT_W'(0);
      end else if (cnt_q < CNT_FULL) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt_q <= CNT_W'(0);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign qualified_o = lock_i & ~clear_i & (cnt_q >= CNT_LAST);

endmodule

// File: rtl/reset_seq_ctrl.sv
// Power-up reset sequencer: waits for PLL lock, holds, then releases domains
// one at a time on acknowledge. Ack timeout/FAULT guarded by RESET_SEQ_TIMEOUT_EN.
module reset_seq_ctrl
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGE   = 3,
   parameter int HOLD_CYCLE  = 16,
   parameter int LOCK_FILTER = 8,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                                i_clk,
   input  logic                                i_srst,
   input  logic                                i_pll_locked,
   input  logic                                i_soft_rst_req,
   input  logic [NUM_STAGE-1:0]                i_stage_ack,
   output logic [NUM_STAGE-1:0]                o_stage_rst,
   output logic                                o_soft_rst_ack,
   output logic                                o_busy,
   output logic                                o_done,
   output logic                                o_timeout,
   output logic [idx_width(NUM_STAGE)-1:0]     o_stage_idx
);

   localparam int IDX_W  = idx_width(NUM_STAGE);
   localparam int HOLD_W = cnt_width(HOLD_CYCLE);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGE - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLE - 1);

   state_e               state_q, state_d;
   logic [NUM_STAGE-1:0] stage_rst_q, stage_rst_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [HOLD_W-1:0]    hold_q, hold_d;
   logic                 soft_ack_q;
   logic                 armed_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 lock_qual_s;
   logic                 lock_clear_s;

`ifdef RESET_SEQ_TIMEOUT_EN
   localparam int TMR_W = cnt_width(ACK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             timeout_q;
`endif

   // The filter only counts while idle in WAIT_LOCK with no soft request.
   assign lock_clear_s = (state_q != ST_WAIT_LOCK) | i_soft_rst_req;

   reset_seq_lock_filter #(
      .LOCK_FILTER (LOCK_FILTER)
   ) u_lock_filter (
      .clk_i       (i_clk),
      .srst_i      (i_srst),
      .clear_i     (lock_clear_s),
      .lock_i      (i_pll_locked),
      .qualified_o (lock_qual_s)
   );

   // Next-state logic; soft request beats every state, lock loss beats all but FAULT.
   always_comb begin
      state_d = state_q;
      if (i_soft_rst_req) begin
         state_d = ST_WAIT_LOCK;
      end else begin
         case (state_q)
            ST_WAIT_LOCK: state_d = lock_qual_s ? ST_HOLD : ST_WAIT_LOCK;
            ST_HOLD: begin
               if (!i_pll_locked) begin
                  state_d = ST_WAIT_LOCK;
               end else if (hold_q >= HOLD_LAST) begin
                  state_d = ST_RELEASE;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_RELEASE: state_d = i_pll_locked ? ST_WAIT_ACK : ST_WAIT_LOCK;
            ST_WAIT_ACK: begin
               if (!i_pll_locked) begin
                  state_d = ST_WAIT_LOCK;
               end else if (i_stage_ack[idx_q]) begin
                  state_d = (idx_q == IDX_LAST) ? ST_RUN : ST_RELEASE;
`ifdef RESET_SEQ_TIMEOUT_EN
               end else if (tmr_q >= TMR_LAST) begin
                  state_d = ST_FAULT;
`endif
               end else begin
                  state_d = ST_WAIT_ACK;
               end
            end
            ST_RUN: state_d = i_pll_locked ? ST_RUN : ST_WAIT_LOCK;
`ifdef RESET_SEQ_TIMEOUT_EN
            ST_FAULT: state_d = ST_FAULT;
`endif
            default: state_d = ST_WAIT_LOCK;
         endcase
      end
   end

   // Datapath keyed on the state being entered; counters only advance while
   // staying in their state, which is below their limit, so they cannot wrap.
   always_comb begin
      stage_rst_d = stage_rst_q;
      idx_d       = idx_q;
      hold_d      = HOLD_W'(0);
`ifdef RESET_SEQ_TIMEOUT_EN
      tmr_d       = TMR_W'(0);
`endif
      case (state_d)
         ST_HOLD: begin
            stage_rst_d = {NUM_STAGE{1'b1}};
            hold_d      = (state_q == ST_HOLD) ? hold_q + HOLD_W'(1) : HOLD_W'(0);
         end
         ST_RELEASE: begin
            idx_d = (state_q == ST_WAIT_ACK) ? idx_q + IDX_W'(1) : IDX_W'(0);
         end
         ST_WAIT_ACK: begin
            if (state_q == ST_RELEASE) begin
               stage_rst_d[idx_q] = 1'b0;
            end else begin
`ifdef RESET_SEQ_TIMEOUT_EN
               tmr_d = tmr_q + TMR_W'(1);
`endif
            end
         end
         ST_RUN: begin
            stage_rst_d = stage_rst_q;
         end
`ifdef RESET_SEQ_TIMEOUT_EN
         ST_FAULT: begin
            stage_rst_d = {NUM_STAGE{1'b1}};
         end
`endif
         ST_WAIT_LOCK: begin
            stage_rst_d = {NUM_STAGE{1'b1}};
            idx_d       = IDX_W'(0);
         end
         default: begin
            stage_rst_d = {NUM_STAGE{1'b1}};
            idx_d       = IDX_W'(0);
         end
      endcase
   end

   // State and registered outputs; the ack re-arms only after a low request sample.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         state_q     <= ST_WAIT_LOCK;
         stage_rst_q <= {NUM_STAGE{1'b1}};
         idx_q       <= IDX_W'(0);
         hold_q      <= HOLD_W'(0);
         soft_ack_q  <= 1'b0;
         armed_q     <= 1'b1;
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         stage_rst_q <= stage_rst_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         soft_ack_q  <= i_soft_rst_req & armed_q;
         armed_q     <= ~i_soft_rst_req;
         busy_q      <= (state_d == ST_WAIT_LOCK) || (state_d == ST_HOLD) ||
                        (state_d == ST_RELEASE)   || (state_d == ST_WAIT_ACK);
         done_q      <= (state_d == ST_RUN);
      end
   end

`ifdef RESET_SEQ_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         tmr_q     <= TMR_W'(0);
         timeout_q <= 1'b0;
      end else begin
         tmr_q     <= tmr_d;
         timeout_q <= (state_d == ST_FAULT);
      end
   end

   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   assign o_stage_rst    = stage_rst_q;
   assign o_soft_rst_ack = soft_ack_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
   assign o_stage_idx    = idx_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Bench for reset_seq_ctrl (NUM_STAGE=3, HOLD_CYCLE=8, LOCK_FILTER=4, ACK_TIMEOUT=16).
// Expected o_stage_rst changes are queued from a timing model and popped as they occur.
module tb_reset_seq_ctrl;

   localparam int HC = 8;
   localparam int LF = 4;
   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       srst;
   logic       pll_locked;
   logic       soft_req;
   logic [2:0] stage_ack;
   logic [2:0] o_stage_rst;
   logic       o_soft_rst_ack;
   logic       o_busy;
   logic       o_done;
   logic       o_timeout;
   logic [1:0] o_stage_idx;

   typedef struct {
      int         edge_no;
      logic [2:0] val;
   } ev_t;

   ev_t        exp_q[$];
   logic [2:0] prev_rst = 3'b111;
   int         edge_n = 0;
   int         checks = 0;
   int         errors = 0;

   reset_seq_ctrl #(
      .NUM_STAGE   (3),
      .HOLD_CYCLE  (HC),
      .LOCK_FILTER (LF),
      .ACK_TIMEOUT (TO)
   ) dut (
      .i_clk          (clk),
      .i_srst         (srst),
      .i_pll_locked   (pll_locked),
      .i_soft_rst_req (soft_req),
      .i_stage_ack    (stage_ack),
      .o_stage_rst    (o_stage_rst),
      .o_soft_rst_ack (o_soft_rst_ack),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_timeout      (o_timeout),
      .o_stage_idx    (o_stage_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic push_ev(input int e, input logic [2:0] v);
      ev_t ev;
      ev.edge_no = e;
      ev.val     = v;
      exp_q.push_back(ev);
   endtask

   // Advance to the negedge after the next posedge and retire any reset change.
   task automatic tick();
      ev_t ev;
      @(negedge clk);
      if (o_stage_rst !== prev_rst) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rst_event: o_stage_rst=%b at edge %0d, required no change", o_stage_rst, edge_n);
         end else begin
            ev = exp_q.pop_front();
            if (ev.val !== o_stage_rst || ev.edge_no != edge_n) begin
               errors++;
               $display("FAIL rst_event: got %b at edge %0d, required %b at edge %0d",
                        o_stage_rst, edge_n, ev.val, ev.edge_no);
            end
         end
      end
      prev_rst = o_stage_rst;
   endtask

   task automatic test_reset();
      srst = 1'b1; pll_locked = 1'b0; soft_req = 1'b0; stage_ack = 3'b000;
      repeat (3) tick();
      checks++;
      if ({o_stage_rst, o_soft_rst_ack, o_busy, o_done, o_timeout, o_stage_idx} !== 9'b111_0_1_0_0_00) begin
         errors++;
         $display("FAIL reset_state: got rst=%b ack=%b busy=%b done=%b to=%b idx=%0d, required 111 0 1 0 0 0",
                  o_stage_rst, o_soft_rst_ack, o_busy, o_done, o_timeout, o_stage_idx);
      end
      srst = 1'b0;
      tick();
   endtask

   // Lock rises (optionally with one low sample after three highs), stages are
   // acked 3 cycles after release, stage 2 after d2 cycles; ends in RUN.
   task automatic seq_up(input int d2, input bit glitch);
      int s, l, r0, r1, r2, dn, nx;
      s  = edge_n + 1;
      l  = glitch ? s + 4 : s;
      r0 = l + LF - 1 + HC + 1;
      r1 = r0 + 4;
      r2 = r1 + 4;
      dn = r2 + d2;
      push_ev(r0, 3'b110);
      push_ev(r1, 3'b100);
      push_ev(r2, 3'b000);
      pll_locked = 1'b1; stage_ack = 3'b000; soft_req = 1'b0;
      while (edge_n < dn) begin
         tick();
         nx = edge_n + 1;
         pll_locked = !(glitch && nx == s + 3);
         if (nx >= dn)          stage_ack = 3'b111;
         else if (nx >= r1 + 3) stage_ack = 3'b011;
         else if (nx >= r0 + 3) stage_ack = 3'b001;
         else if (nx == r0 + 1) stage_ack = 3'b110;
         else                   stage_ack = 3'b000;
         if (edge_n == r1) begin
            checks++;
            if (o_stage_idx !== 2'd1) begin
               errors++;
               $display("FAIL stage_idx: got %0d, required 1", o_stage_idx);
            end
         end
         if (edge_n == dn - 1) begin
            checks++;
            if ({o_done, o_busy, o_timeout} !== 3'b010) begin
               errors++;
               $display("FAIL wait_last_ack: got done=%b busy=%b to=%b, required 0 1 0", o_done, o_busy, o_timeout);
            end
         end
      end
      checks++;
      if ({o_done, o_busy, o_timeout, o_stage_idx} !== 5'b100_10) begin
         errors++;
         $display("FAIL run_state: got done=%b busy=%b to=%b idx=%0d, required 1 0 0 2",
                  o_done, o_busy, o_timeout, o_stage_idx);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL seq_pending: %0d reset changes missing, required 0", exp_q.size());
      end
   endtask

   task automatic test_sequence();
      while (edge_n < 9) tick();
      seq_up(3, 1'b0);
   endtask

   task automatic test_lock_drop();
      push_ev(edge_n + 1, 3'b111);
      pll_locked = 1'b0;
      tick();
      checks++;
      if ({o_done, o_busy} !== 2'b01) begin
         errors++;
         $display("FAIL lock_drop: got done=%b busy=%b, required 0 1", o_done, o_busy);
      end
      seq_up(3, 1'b1);
   endtask

   task automatic test_soft_req(input bit with_lock_drop);
      logic exp_ack;
      push_ev(edge_n + 1, 3'b111);
      soft_req = 1'b1;
      if (with_lock_drop) pll_locked = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pll_locked = 1'b1;
         exp_ack = (i == 0);
         checks++;
         if (o_soft_rst_ack !== exp_ack || o_busy !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL soft_ack cycle %0d: got ack=%b busy=%b done=%b, required %b 1 0",
                     i, o_soft_rst_ack, o_busy, o_done, exp_ack);
         end
      end
      soft_req = 1'b0;
      seq_up(3, 1'b0);
   endtask

`ifdef RESET_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int s, r0, r1, f, nx;
      push_ev(edge_n + 1, 3'b111);
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      s  = edge_n + 1;
      r0 = s + LF - 1 + HC + 1;
      r1 = r0 + 4;
      f  = r1 + TO;
      push_ev(r0, 3'b110);
      push_ev(r1, 3'b100);
      push_ev(f,  3'b111);
      pll_locked = 1'b1; stage_ack = 3'b000;
      while (edge_n < f + 3) begin
         tick();
         nx = edge_n + 1;
         stage_ack  = (nx >= r0 + 3) ? 3'b101 : 3'b000;
         pll_locked = !(nx == f + 2);
         if (edge_n == f - 1) begin
            checks++;
            if ({o_timeout, o_busy} !== 2'b01) begin
               errors++;
               $display("FAIL pre_timeout: got to=%b busy=%b, required 0 1", o_timeout, o_busy);
            end
         end
         if (edge_n == f) begin
            checks++;
            if ({o_timeout, o_busy, o_done} !== 3'b100) begin
               errors++;
               $display("FAIL timeout: got to=%b busy=%b done=%b, required 1 0 0", o_timeout, o_busy, o_done);
            end
         end
      end
      checks++;
      if ({o_timeout, o_busy} !== 2'b10) begin
         errors++;
         $display("FAIL fault_lock_loss: got to=%b busy=%b, required 1 0", o_timeout, o_busy);
      end
      soft_req = 1'b1;
      tick();
      checks++;
      if ({o_soft_rst_ack, o_timeout, o_busy} !== 3'b101) begin
         errors++;
         $display("FAIL fault_exit: got ack=%b to=%b busy=%b, required 1 0 1", o_soft_rst_ack, o_timeout, o_busy);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_pending: %0d reset changes missing, required 0", exp_q.size());
      end
      soft_req = 1'b0;
      seq_up(3, 1'b0);
   endtask
`else
   task automatic test_no_timeout();
      push_ev(edge_n + 1, 3'b111);
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      seq_up(100, 1'b0);
   endtask
`endif

   task automatic test_srst_mid();
      int s, r0;
      push_ev(edge_n + 1, 3'b111);
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      s  = edge_n + 1;
      r0 = s + LF - 1 + HC + 1;
      push_ev(r0, 3'b110);
      push_ev(r0 + 2, 3'b111);
      pll_locked = 1'b1; stage_ack = 3'b000;
      while (edge_n < r0 + 1) tick();
      srst = 1'b1; soft_req = 1'b1;
      tick();
      checks++;
      if ({o_soft_rst_ack, o_busy, o_done, o_timeout, o_stage_idx} !== 6'b0_1_0_0_00) begin
         errors++;
         $display("FAIL srst_mid: got ack=%b busy=%b done=%b to=%b idx=%0d, required 0 1 0 0 0",
                  o_soft_rst_ack, o_busy, o_done, o_timeout, o_stage_idx);
      end
      srst = 1'b0; soft_req = 1'b0; pll_locked = 1'b0;
      tick();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL srst_pending: %0d reset changes missing, required 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_lock_drop();
      test_soft_req(1'b0);
      test_soft_req(1'b1);
`ifdef RESET_SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_srst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_seq_ctrl.md
RESET_SEQ_CTRL -- requirements
Module: reset_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGE, default 3: number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter HOLD_CYCLE, default 16: cycles all resets stay asserted after lock qualifies (>=1).
REQ-003 SHALL have parameter LOCK_FILTER, default 8: consecutive high samples of i_pll_locked needed to qualify lock (>=1).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1024: maximum cycles to wait for one stage acknowledge (>=1).
REQ-005 SHALL use one clock and a synchronous active-high reset; ports in this order: i_clk input 1 (sole clock), i_srst input 1 (synchronous active-high reset).
REQ-006 SHALL have the following ports: i_pll_locked input 1 (PLL lock, already synchronous to i_clk); i_soft_rst_req input 1 (level soft-reset request); i_stage_ack input NUM_STAGE (per-domain ready/calibration done); o_stage_rst output NUM_STAGE (active-high per-domain reset); o_soft_rst_ack output 1 (one-cycle accept pulse); o_busy output 1; o_done output 1; o_timeout output 1; o_stage_idx output clog2(NUM_STAGE) or 1 (current stage index).

Function
REQ-007 SHALL implement the FSM states WAIT_LOCK, HOLD, RELEASE, WAIT_ACK, RUN and FAULT, with all outputs registered.
REQ-008 In WAIT_LOCK: all o_stage_rst=1; any low sample of i_pll_locked clears the lock counter; the edge giving the LOCK_FILTER-th consecutive high sample enters HOLD.
REQ-009 In HOLD: all resets asserted; entered at edge E, it SHALL go to RELEASE at edge E+HOLD_CYCLE with o_stage_idx=0.
REQ-010 In RELEASE: at the next edge, o_stage_rst[o_stage_idx] SHALL go to 0, the FSM SHALL go to WAIT_ACK, and the ack timer SHALL be cleared.
REQ-011 Released stages SHALL stay released; stage k SHALL never be released before stage k-1 is acknowledged.
REQ-012 In WAIT_ACK: if i_stage_ack[idx] is sampled 1 at edge N and idx<NUM_STAGE-1, idx SHALL increment and the FSM SHALL enter RELEASE, so o_stage_rst[idx+1] falls at edge N+1; if idx=NUM_STAGE-1, the FSM SHALL enter RUN at edge N.
REQ-013 i_stage_ack of stages other than the current index SHALL be ignored.
REQ-014 In RUN: o_done=1; i_pll_locked sampled 0 SHALL reassert all o_stage_rst at the next edge and go to WAIT_LOCK.
REQ-015 In HOLD, RELEASE or WAIT_ACK, a lock loss SHALL likewise reassert all resets and go to WAIT_LOCK.
REQ-016 In any state, i_soft_rst_req=1 sampled SHALL reassert all resets, pulse o_soft_rst_ack for exactly one cycle, clear o_timeout, and go to WAIT_LOCK.
REQ-017 A further ack SHALL only be issued after i_soft_rst_req has been sampled 0 at least once.
REQ-018 If soft request and lock loss coincide, the result SHALL be WAIT_LOCK with the ack pulsed.
REQ-019 o_busy SHALL be 1 in WAIT_LOCK, HOLD, RELEASE and WAIT_ACK, and 0 otherwise.
REQ-020 o_done SHALL be 1 only in RUN.
REQ-021 The hold, lock and ack counters SHALL saturate and never wrap; counter widths SHALL be clog2 of parameter+1.

Reset
REQ-022 i_srst=1 SHALL force: o_stage_rst all 1, o_soft_rst_ack=0, o_busy=1, o_done=0, o_timeout=0, o_stage_idx=0, all counters 0, state WAIT_LOCK.
REQ-023 i_srst SHALL override every other input at the same edge, including mid-sequence and in FAULT.

Configuration
REQ-024 Macro RESET_SEQ_TIMEOUT_EN, when defined: ACK_TIMEOUT cycles in WAIT_ACK without ack SHALL enter FAULT with o_timeout=1, all resets reasserted, and lock loss ignored; exit from FAULT SHALL only be by soft request or i_srst.
REQ-025 Without RESET_SEQ_TIMEOUT_EN: WAIT_ACK SHALL wait indefinitely, the ack timer and FAULT state SHALL be absent, and o_timeout SHALL be tied 0.

Structure
REQ-026 A shared package reset_seq_pkg SHALL hold the state enum typedef and encodings, plus the clog2-width helper constants.
REQ-027 Sub-module reset_seq_lock_filter SHALL implement the LOCK_FILTER consecutive-sample qualifier with clear and qualified outputs.

Verification (NUM_STAGE=3, HOLD_CYCLE=8, LOCK_FILTER=4, ACK_TIMEOUT=16, macro defined unless stated)
REQ-028 Lock high from cycle 10 and acks returned 3 cycles after each release -> HOLD at edge 13, o_stage_rst[0] falls at edge 22, stage order 0,1,2, then o_done=1 and o_busy=0.
REQ-029 Lock toggling 1,1,1,0,1,1,1,1 -> HOLD entered only on the 4th high of the second run, and all resets stay 1 throughout.
REQ-030 Stage 1 ack never returned -> FAULT 16 cycles after the stage 1 release with o_timeout=1 and o_stage_rst=3'b111; a soft request then gives a 1-cycle ack and WAIT_LOCK with o_timeout=0.
REQ-031 In RUN, drop lock for 1 cycle -> o_stage_rst=3'b111 at the next edge, o_done=0, and a full resequence follows.
REQ-032 Hold i_soft_rst_req high for 5 cycles in RUN -> exactly one o_soft_rst_ack pulse; a simultaneous lock drop gives the same result.
REQ-033 Macro undefined with stage 2 ack withheld for 100 cycles -> remains in WAIT_ACK with o_timeout=0, then completes to RUN once the ack arrives.
